// File: rtl/fetch_stage_if.sv
// Fetch stage bus bundle: instruction memory req/gnt/rvalid
// plus the valid/ready handoff to decode and next-PC selection.
interface fetch_stage_if;
    logic        imem_req_o;
    logic [31:0] imem_addr_o;
    logic        imem_gnt_i;
    logic        imem_rvalid_i;
    logic [31:0] imem_rdata_i;
    logic        imem_err_i;
    logic        instr_valid_o;
    logic        instr_ready_i;
    logic [31:0] instr_o;
    logic [31:0] pc_o;
    logic [31:0] pc_plus4_o;
    logic [1:0]  pc_source_i;
    logic [31:0] branch_target_i;
    logic [31:0] jalr_target_i;
    logic        fetch_error_o;
    logic [31:0] retired_count_o;

    modport master (
        output imem_req_o,
        output imem_addr_o,
        input  imem_gnt_i,
        input  imem_rvalid_i,
        input  imem_rdata_i,
        input  imem_err_i,
        output instr_valid_o,
        input  instr_ready_i,
        output instr_o,
        output pc_o,
        output pc_plus4_o,
        input  pc_source_i,
        input  branch_target_i,
        input  jalr_target_i,
        output fetch_error_o,
        output retired_count_o
    );

    modport slave (
        input  imem_req_o,
        input  imem_addr_o,
        output imem_gnt_i,
        output imem_rvalid_i,
        output imem_rdata_i,
        output imem_err_i,
        input  instr_valid_o,
        output instr_ready_i,
        input  instr_o,
        input  pc_o,
        input  pc_plus4_o,
        output pc_source_i,
        output branch_target_i,
        output jalr_target_i,
        input  fetch_error_o,
        input  retired_count_o
    );
endinterface

// File: rtl/fetch_stage.sv
// Instruction fetch stage: owns the PC, issues one imem request at
// a time and holds the returned word until decode accepts it.
module fetch_stage #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
    input logic           clk_i,
    input logic           rst_ni,
    fetch_stage_if.master bus
);

    typedef enum logic [1:0] {
        REQ,
        WAIT,
        HOLD,
        ERROR
    } state_e;

    state_e      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] instr_q, instr_d;
    logic [31:0] cnt_q, cnt_d;
    logic        req_q, req_d;
    logic        valid_q, valid_d;
    logic        err_q, err_d;
    logic [31:0] pc_plus4;
    logic [31:0] next_pc;

    assign pc_plus4 = pc_q + 32'd4;

    always_comb begin
        next_pc = pc_plus4;
        unique case (bus.pc_source_i)
            2'b01:   next_pc = bus.branch_target_i;
            2'b10:   next_pc = {bus.jalr_target_i[31:1], 1'b0};
            default: next_pc = pc_plus4;
        endcase
    end

    // req/valid/err are registered so they follow the next state
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        instr_d = instr_q;
        cnt_d   = cnt_q;
        req_d   = req_q;
        valid_d = valid_q;
        err_d   = err_q;
        unique case (state_q)
            REQ: begin
                req_d = 1'b1;
                if (req_q && bus.imem_gnt_i) begin
                    state_d = WAIT;
                    req_d   = 1'b0;
                end
            end
            WAIT: begin
                if (bus.imem_rvalid_i) begin
                    if (bus.imem_err_i) begin
                        state_d = ERROR;
                        err_d   = 1'b1;
                    end else begin
                        state_d = HOLD;
                        instr_d = bus.imem_rdata_i;
                        valid_d = 1'b1;
                    end
                end
            end
            HOLD: begin
                if (bus.instr_ready_i) begin
                    valid_d = 1'b0;
                    if (next_pc[1:0] != 2'b00) begin
                        state_d = ERROR;
                        err_d   = 1'b1;
                    end else begin
                        state_d = REQ;
                        pc_d    = next_pc;
                        cnt_d   = cnt_q + 32'd1;
                        instr_d = NOP_INSTR;
                        req_d   = 1'b1;
                    end
                end
            end
            ERROR: begin
                req_d   = 1'b0;
                valid_d = 1'b0;
                err_d   = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= REQ;
            pc_q    <= RESET_PC;
            instr_q <= NOP_INSTR;
            cnt_q   <= 32'd0;
            req_q   <= 1'b0;
            valid_q <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            instr_q <= instr_d;
            cnt_q   <= cnt_d;
            req_q   <= req_d;
            valid_q <= valid_d;
            err_q   <= err_d;
        end
    end

    assign bus.imem_req_o      = req_q;
    assign bus.imem_addr_o     = pc_q;
    assign bus.instr_valid_o   = valid_q;
    assign bus.instr_o         = instr_q;
    assign bus.pc_o            = pc_q;
    assign bus.pc_plus4_o      = pc_plus4;
    assign bus.fetch_error_o   = err_q;
    assign bus.retired_count_o = cnt_q;

endmodule

// File: doc/fetch_stage.md
Name: fetch_stage

Overview:
- Instruction fetch stage that sits directly upstream of the decode/control logic.
- Owns the program counter and issues one request at a time to instruction memory over a req/gnt/rvalid bus.
- Holds the returned instruction and presents it with PC and PC+4 to decode via a valid/ready handshake.
- On acceptance, selects the next PC from the pc_source code that the control path produces for the held instruction. Also keeps a count of accepted instructions.

Parameters:
RESET_PC, 32'h0000_0000, PC loaded on reset; must be 4-byte aligned.
NOP_INSTR, 32'h0000_0013, value driven on instr_o when no instruction is held (addi x0,x0,0).

Ports:
clk_i  input  1  clock, all state on rising edge
rst_ni  input  1  reset, asynchronous, active-low
imem_req_o  output  1  fetch request valid
imem_addr_o  output  32  fetch byte address, always equal to pc_o
imem_gnt_i  input  1  request accepted this cycle
imem_rvalid_i  input  1  response valid; earliest one cycle after gnt
imem_rdata_i  input  32  instruction word
imem_err_i  input  1  access fault; qualified by imem_rvalid_i
instr_valid_o  output  1  instr_o/pc_o/pc_plus4_o valid
instr_ready_i  input  1  decode accepts the held instruction
instr_o  output  32  held instruction word
pc_o  output  32  PC of the held instruction / current fetch address
pc_plus4_o  output  32  pc_o + 4, link value for jal/jalr
pc_source_i  input  2  next-PC select, sampled on accept: 00 pc+4, 01 branch_target_i, 10 jalr_target_i, 11 reserved (treated as pc+4)
branch_target_i  input  32  pc+imm target for taken branches and jal
jalr_target_i  input  32  ALU result for jalr; bit 0 is cleared internally
fetch_error_o  output  1  sticky fault flag
retired_count_o  output  32  number of accepted instructions

Behaviour:
- Reset (rst_ni low, async):
  - state=REQ, pc=RESET_PC, instr_o=NOP_INSTR.
  - instr_valid_o=0, imem_req_o=0 while reset is asserted.
  - fetch_error_o=0, retired_count_o=0.
- FSM states: REQ, WAIT, HOLD, ERROR.
- REQ:
  - imem_req_o=1, imem_addr_o=pc.
  - imem_gnt_i=1 -> WAIT; otherwise stay in REQ, holding the address stable.
- WAIT:
  - imem_req_o=0.
  - imem_rvalid_i=1 and imem_err_i=0 -> capture imem_rdata_i into instr register, go to HOLD.
  - imem_rvalid_i=1 and imem_err_i=1 -> ERROR.
  - imem_gnt_i is ignored in WAIT.
- HOLD:
  - instr_valid_o=1; instr_o, pc_o and pc_plus4_o are stable until accepted.
  - On instr_ready_i=1:
    - next_pc is selected by pc_source_i; for 10, next_pc = jalr_target_i with bit 0 forced to 0.
    - If next_pc[1:0] != 0 -> ERROR, pc unchanged.
    - Otherwise pc <= next_pc, retired_count_o += 1, instr_o <= NOP_INSTR, go to REQ.
- ERROR:
  - fetch_error_o=1; imem_req_o=0; instr_valid_o=0.
  - Left only by reset. pc_o holds the faulting or pre-fault PC.
- pc_source_i, branch_target_i and jalr_target_i are don't-care except in the HOLD-and-ready cycle.
- Timing:
  - Minimum throughput is one instruction per 3 cycles: gnt in the REQ cycle, rvalid the next cycle, accept in HOLD.
  - Stall cycles add to this linearly.
- Arithmetic:
  - pc_plus4_o wraps modulo 2^32 (32'hFFFF_FFFC + 4 = 0); no fault on wrap.
  - retired_count_o wraps from 32'hFFFF_FFFF to 0.
- instr_ready_i is ignored outside HOLD. Decode must not rely on acceptance when instr_valid_o=0.
- Reset deasserted mid-transaction: any outstanding response arriving after reset is dropped. The bus must not deliver a stale rvalid while the stage is in REQ; rvalid in REQ is ignored.

Test Plan:
- Reset then zero-wait memory (gnt in REQ cycle, rvalid next cycle), decode ready=1, pc_source=00 -> addresses 0,4,8 on consecutive fetches; instr_valid_o high every third cycle; retired_count_o=3 after three accepts.
- gnt delayed 2 cycles, rvalid delayed 3 cycles -> imem_addr_o stable during REQ stall; instr_o equals returned data; retired_count_o unchanged until accept.
- In HOLD at pc=0x10: pc_source=01, branch_target=0x40 -> next request address 0x40. Then pc_source=10, jalr_target=0x81 -> next address 0x80, pc_plus4_o=0x84 once held.
- pc_source=01, branch_target=0x42 -> fetch_error_o=1, imem_req_o stays 0, pc_o=pc of faulting instruction; only rst_ni low clears it.
- imem_err_i=1 with rvalid at pc=0x100 -> ERROR, instr_valid_o never asserts, fetch_error_o=1.
- HOLD with instr_ready_i=0 for 5 cycles, then rst_ni pulsed low -> outputs hold stable during the stall; after reset pc_o=RESET_PC, instr_o=0x00000013, retired_count_o=0, request reissued at RESET_PC.
